core_exec_ctrl: RTL and testbench
=================================

// Module: core_exec_ctrl
// PURPOSE
//  Run-control sequencer for the 4-bit accumulator core: holds core in reset while imem is
//  loaded over a valid/ready port, then sequences execution (run, single-step, halt,
//  PC breakpoint) by gating the core's per-cycle enable. Sits between the debug/host
//  interface and the core top; counts executed cycles for status.
// PARAMETERS
//  PC_W    4   program counter / imem address width
//  INST_W  8   instruction width
//  CYC_W   16  executed-cycle counter width
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  ld_valid   in   1       load word valid
//  ld_ready   out  1       load word accepted this cycle
//  ld_addr    in   PC_W    imem address for load word
//  ld_data    in   INST_W  instruction word to load
//  imem_we    out  1       imem write strobe
//  imem_waddr out  PC_W    imem write address
//  imem_wdata out  INST_W  imem write data
//  cmd_run    in   1       pulse: free-run
//  cmd_step   in   1       pulse: execute exactly one cycle
//  cmd_halt   in   1       pulse: stop execution
//  cmd_clear  in   1       pulse: return to IDLE, core back in reset
//  bp_en      in   1       breakpoint enable
//  bp_addr    in   PC_W    breakpoint PC
//  core_pc    in   PC_W    current core PC
//  core_en    out  1       core advance enable (PC, regs, carry flag update)
//  core_rst   out  1       active-high hold-in-reset; top inverts to core resetn
//  state      out  2       IDLE=0, RUN=1, STEP=2, HALT=3
//  bp_hit     out  1       sticky: halted by breakpoint
//  cycle_cnt  out  CYC_W   cycles with core_en=1, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, bp_hit=0, cycle_cnt=0, resume mask=0; outputs decode to
//    core_rst=1, core_en=0, ld_ready=1, imem_we=0 in the first post-reset cycle.
//  - core_rst = (state==IDLE); ld_ready = (state==IDLE). Combinational from state.
//  - Load: imem_we = ld_valid & ld_ready; imem_waddr/wdata = ld_addr/ld_data, same cycle,
//    zero latency. ld_valid outside IDLE stalls (ld_ready=0), no write, no data loss.
//  - Command priority when several pulse together: clear > halt > step > run.
//  - IDLE: run->RUN; step->STEP; halt ignored. Load + command in same cycle: write
//    occurs, state changes next cycle.
//  - RUN: core_en=1 unless bp_match; halt->HALT (halt cycle itself has core_en=1
//    only if no bp_match; halt takes effect next cycle).
//  - bp_match = bp_en & (core_pc==bp_addr) & ~resume_mask & state==RUN.
//    On bp_match: core_en=0 that cycle, bp_hit<=1, state<=HALT. Instruction at bp_addr
//    not executed.
//  - resume_mask set when leaving HALT to RUN; cleared after first RUN cycle, so resume
//    at bp_addr executes it once. Later returns to bp_addr break again.
//  - STEP: core_en=1 for exactly one cycle, then HALT. Breakpoint not checked in STEP.
//  - HALT: core_en=0. run->RUN; step->STEP; halt no-op. Leaving HALT clears bp_hit.
//  - clear (any state): ->IDLE next cycle, cycle_cnt<=0, bp_hit<=0; core_en=0 in clear
//    cycle.
//  - cycle_cnt += 1 on every cycle with core_en=1; holds at 2^CYC_W-1 (no wrap).
//  - Core PC wrap (15->0) is transparent; breakpoint compares on raw PC only.
//  - Reset mid-load or mid-run: aborts; imem_we forced 0 during reset cycle; imem
//    contents untouched.
// TESTING
//  1. Load 16 words 0x00..0x0F with ld_valid held; ld_ready=1 throughout ->
//     16 imem_we pulses, addr 0..15.
//  2. cmd_run after load -> core_rst falls next cycle; core_en=1; cycle_cnt counts
//     1,2,3...
//  3. bp_en=1,bp_addr=5, run -> halts with core_pc=5, core_en=0, bp_hit=1; cmd_run ->
//     PC 5 executes once, bp_hit=0.
//  4. From HALT, three cmd_step pulses spaced 4 cycles -> exactly 3 core_en pulses,
//     cycle_cnt +3.
//  5. Same-cycle cmd_run+cmd_halt+cmd_clear in RUN -> IDLE, core_rst=1,
//     cycle_cnt=0; ld_valid in RUN -> ld_ready=0, no imem_we.
//  6. CYC_W=4 run 20 cycles -> cycle_cnt sticks at 15; reset mid-run -> state=0,
//     outputs at reset values.

Source files
------------

// File: rtl/core_exec_ctrl.sv
// Run-control sequencer for the 4-bit accumulator core: gates imem loading while idle,
// then sequences run / single-step / halt / PC breakpoint via the core advance enable.
module core_exec_ctrl #(
  parameter int PC_W   = 4,
  parameter int INST_W = 8,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [INST_W-1:0] ld_data,
  output logic              imem_we,
  output logic [PC_W-1:0]   imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              cmd_clear,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   core_pc,
  output logic              core_en,
  output logic              core_rst,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [CYC_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_bp_hit, w_bp_hit_nxt;
  logic             r_resume, w_resume_nxt;
  logic [CYC_W-1:0] r_cycle_cnt;
  logic             w_bp_match;
  logic             w_core_en;

  assign w_bp_match = bp_en & (core_pc == bp_addr) & ~r_resume & (r_state == S_RUN);

  assign core_rst   = (r_state == S_IDLE);
  assign ld_ready   = (r_state == S_IDLE);
  assign imem_we    = ld_valid & ld_ready & ~reset;
  assign imem_waddr = ld_addr;
  assign imem_wdata = ld_data;
  assign core_en    = w_core_en;
  assign state      = r_state;
  assign bp_hit     = r_bp_hit;
  assign cycle_cnt  = r_cycle_cnt;

  // A pending halt masks step/run in every state, giving clear > halt > step > run.
  always_comb begin
    w_state_nxt  = r_state;
    w_bp_hit_nxt = r_bp_hit;
    w_resume_nxt = r_resume;
    w_core_en    = 1'b0;
    if (cmd_clear) begin
      w_state_nxt  = S_IDLE;
      w_bp_hit_nxt = 1'b0;
      w_resume_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!cmd_halt) begin
            if (cmd_step)     w_state_nxt = S_STEP;
            else if (cmd_run) w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          w_core_en    = ~w_bp_match;
          w_resume_nxt = 1'b0;
          if (w_bp_match) begin
            w_state_nxt  = S_HALT;
            w_bp_hit_nxt = 1'b1;
          end else if (cmd_halt) begin
            w_state_nxt = S_HALT;
          end
        end
        S_STEP: begin
          w_core_en   = 1'b1;
          w_state_nxt = S_HALT;
        end
        S_HALT: begin
          if (!cmd_halt) begin
            if (cmd_step) begin
              w_state_nxt  = S_STEP;
              w_bp_hit_nxt = 1'b0;
            end else if (cmd_run) begin
              w_state_nxt  = S_RUN;
              w_bp_hit_nxt = 1'b0;
              w_resume_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bp_hit    <= 1'b0;
      r_resume    <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bp_hit <= w_bp_hit_nxt;
      r_resume <= w_resume_nxt;
      if (cmd_clear)
        r_cycle_cnt <= '0;
      else if (w_core_en && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Bench for core_exec_ctrl: directed scenarios then random commands, compared against a
// behavioural run-control model; a second instance with a 4-bit counter checks saturation.
module tb_core_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset, ld_valid, cmd_run, cmd_step, cmd_halt, cmd_clear, bp_en;
  logic [3:0] ld_addr, bp_addr, core_pc;
  logic [7:0] ld_data;

  logic        a_ld_ready, a_imem_we, a_core_en, a_core_rst, a_bp_hit;
  logic [3:0]  a_imem_waddr;
  logic [7:0]  a_imem_wdata;
  logic [1:0]  a_state;
  logic [15:0] a_cycle_cnt;

  logic        b_ld_ready, b_imem_we, b_core_en, b_core_rst, b_bp_hit;
  logic [3:0]  b_imem_waddr;
  logic [7:0]  b_imem_wdata;
  logic [1:0]  b_state;
  logic [3:0]  b_cycle_cnt;

  core_exec_ctrl u_dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(a_ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_we(a_imem_we),
    .imem_waddr(a_imem_waddr), .imem_wdata(a_imem_wdata), .cmd_run(cmd_run),
    .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_clear(cmd_clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_pc(core_pc), .core_en(a_core_en), .core_rst(a_core_rst),
    .state(a_state), .bp_hit(a_bp_hit), .cycle_cnt(a_cycle_cnt)
  );

  core_exec_ctrl #(.CYC_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(b_ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_we(b_imem_we),
    .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata), .cmd_run(cmd_run),
    .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_clear(cmd_clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_pc(core_pc), .core_en(b_core_en), .core_rst(b_core_rst),
    .state(b_state), .bp_hit(b_bp_hit), .cycle_cnt(b_cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode 0=idle 1=run 2=step 3=halt, plus a simulated core PC.
  int m_state, m_hit, m_res, m_pc, m_cnt16, m_cnt4;
  int e_match, e_en, e_we;
  int n_bp_en = 0;
  int n_bp_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int r, input int lv, input int la, input int ld,
                     input int run, input int step, input int halt, input int clr);
    @(negedge clk);
    reset = 1'(r); ld_valid = 1'(lv); ld_addr = 4'(la); ld_data = 8'(ld);
    cmd_run = 1'(run); cmd_step = 1'(step); cmd_halt = 1'(halt); cmd_clear = 1'(clr);
    bp_en = 1'(n_bp_en); bp_addr = 4'(n_bp_addr); core_pc = 4'(m_pc);
    #1;
    e_match = (n_bp_en != 0 && m_pc == n_bp_addr && m_res == 0 && m_state == 1) ? 1 : 0;
    e_en    = (clr == 0 && ((m_state == 1 && e_match == 0) || m_state == 2)) ? 1 : 0;
    e_we    = (lv != 0 && m_state == 0 && r == 0) ? 1 : 0;
    chk("state",     32'(a_state),      32'(m_state));
    chk("core_en",   32'(a_core_en),    32'(e_en));
    chk("core_rst",  32'(a_core_rst),   32'(m_state == 0));
    chk("ld_ready",  32'(a_ld_ready),   32'(m_state == 0));
    chk("imem_we",   32'(a_imem_we),    32'(e_we));
    chk("waddr",     32'(a_imem_waddr), 32'(la));
    chk("wdata",     32'(a_imem_wdata), 32'(ld));
    chk("bp_hit",    32'(a_bp_hit),     32'(m_hit));
    chk("cnt16",     32'(a_cycle_cnt),  32'(m_cnt16));
    chk("cnt4",      32'(b_cycle_cnt),  32'(m_cnt4));
    chk("b_state",   32'(b_state),      32'(m_state));
    chk("b_core_en", 32'(b_core_en),    32'(e_en));
    chk("b_misc",    32'({b_core_rst, b_ld_ready, b_imem_we, b_bp_hit, b_imem_waddr, b_imem_wdata}),
                     32'({m_state == 0, m_state == 0, e_we[0], m_hit[0], la[3:0], ld[7:0]}));
    @(posedge clk);
    if (r != 0) begin
      m_state = 0; m_hit = 0; m_res = 0; m_cnt16 = 0; m_cnt4 = 0; m_pc = 0;
    end else begin
      if (m_state == 0) m_pc = 0;
      else if (e_en != 0) m_pc = (m_pc + 1) % 16;
      if (clr != 0) begin
        m_state = 0; m_hit = 0; m_res = 0; m_cnt16 = 0; m_cnt4 = 0;
      end else begin
        if (e_en != 0) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        case (m_state)
          0: if (halt == 0) begin
               if (step != 0) m_state = 2;
               else if (run != 0) m_state = 1;
             end
          1: begin
               m_res = 0;
               if (e_match != 0) begin m_state = 3; m_hit = 1; end
               else if (halt != 0) m_state = 3;
             end
          2: m_state = 3;
          default: if (halt == 0) begin
               if (step != 0) begin m_state = 2; m_hit = 0; end
               else if (run != 0) begin m_state = 1; m_hit = 0; m_res = 1; end
             end
        endcase
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int c0;

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; cmd_run = 1'b0;
    cmd_step = 1'b0; cmd_halt = 1'b0; cmd_clear = 1'b0; bp_en = 1'b0; bp_addr = '0;
    core_pc = '0;
    m_state = 0; m_hit = 0; m_res = 0; m_pc = 0; m_cnt16 = 0; m_cnt4 = 0;
    repeat (2) @(posedge clk);

    // Reset values, then load 16 words while idle.
    idle(1);
    for (int i = 0; i < 16; i++) cyc(0, 1, i, i, 0, 0, 0, 0);

    // Run with a breakpoint at 5, then resume through it and break again on wrap.
    n_bp_en = 1; n_bp_addr = 5;
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    idle(8);
    chk("bp_halt_state", 32'(a_state), 32'd3);
    chk("bp_halt_hit",   32'(a_bp_hit), 32'd1);
    chk("bp_halt_pc",    32'(m_pc), 32'd5);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    idle(20);

    // Three spaced single steps from HALT.
    n_bp_en = 0;
    c0 = m_cnt16;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
    end
    chk("step_cnt", 32'(a_cycle_cnt), 32'(c0 + 3));

    // Run, stalled load attempt, then combined run+halt+clear.
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 3, 8'hA5, 0, 0, 0, 0);
    cyc(0, 1, 4, 8'h5A, 1, 0, 1, 1);
    idle(1);
    chk("clear_rst", 32'(a_core_rst), 32'd1);
    chk("clear_cnt", 32'(a_cycle_cnt), 32'd0);

    // Load + run together, then let the 4-bit counter saturate.
    cyc(0, 1, 9, 8'h3C, 1, 0, 0, 0);
    idle(20);
    chk("sat4", 32'(b_cycle_cnt), 32'd15);

    // Reset mid-run, with a load attempt in the reset cycle.
    cyc(1, 1, 2, 8'h77, 0, 0, 0, 0);
    idle(1);
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_cnt",   32'(a_cycle_cnt), 32'd0);

    // Random command mix.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 31) == 0) n_bp_en = int'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) n_bp_addr = int'($urandom_range(0, 15));
      cyc(($urandom_range(0, 299) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 11) == 0) ? 1 : 0,
          ($urandom_range(0, 13) == 0) ? 1 : 0, ($urandom_range(0, 59) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
